// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap sequencer: state encoding and default tap geometry.
package fir_pkg;

  localparam int TAPS_DEF   = 6;
  localparam int BITS_I_DEF = 3;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] ACCUM = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = IDLE,
    S_CLEAR = CLEAR,
    S_ACCUM = ACCUM,
    S_SHIFT = SHIFT,
    S_DONE  = DONE
  } state_t;

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Control bus between the sample source / FIR datapath (master) and the tap sequencer (slave).
// START is a single-cycle request with no ready: it is accepted only in IDLE or DONE and dropped otherwise.
interface fir_tap_sequencer_if #(
  parameter int BITS_I = 3
);

  logic              START;
  logic [BITS_I-1:0] I;
  logic              CLR;
  logic              EN;
  logic              SHIFT;
  logic              DONE;
  logic              BUSY;
  logic              OVR;

  modport master (
    output START,
    input  I, CLR, EN, SHIFT, DONE, BUSY, OVR
  );

  modport slave (
    input  START,
    output I, CLR, EN, SHIFT, DONE, BUSY, OVR
  );

endinterface

// File: rtl/fir_tap_cnt.sv
// Loadable tap counter; holds at TAPS and flags terminal count so the select never runs past the last tap.
module fir_tap_cnt #(
  parameter int W    = 3,
  parameter int TAPS = 6
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] TC_VAL = W'(TAPS);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC_VAL);

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequences clear / tap accumulate / delay-line shift / done for a time-multiplexed FIR MAC.
// Optional sticky overrun flag enabled by defining FIR_TAP_SEQUENCER_OVR_EN.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int bits_I = BITS_I_DEF,
  parameter int TAPS   = TAPS_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  fir_tap_sequencer_if.slave   seq_if,
  output state_t               dbg_state_o
);

  state_t              state_q, state_d;
  logic                cnt_load, cnt_en, cnt_tc;
  logic [bits_I-1:0]   cnt_load_val, cnt;
  logic                clr_q, en_q, shift_q, done_q, busy_q;

  fir_tap_cnt #(
    .W    (bits_I),
    .TAPS (TAPS)
  ) u_cnt (
    .clk_i      (CLK),
    .rst_i      (RST),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .cnt_o      (cnt),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    unique case (state_q)
      S_IDLE:  if (seq_if.START) state_d = S_CLEAR;
      S_CLEAR: begin
        state_d      = S_ACCUM;
        cnt_load     = 1'b1;
        cnt_load_val = bits_I'(1);
      end
      S_ACCUM: begin
        // Park the counter at 0 on the last tap so I never shows a value outside 1..TAPS.
        if (cnt_tc) begin
          state_d  = S_SHIFT;
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_SHIFT: state_d = S_DONE;
      S_DONE:  state_d = seq_if.START ? S_CLEAR : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      shift_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= (state_d == S_CLEAR);
      en_q    <= (state_d == S_ACCUM);
      shift_q <= (state_d == S_SHIFT);
      done_q  <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign seq_if.I     = (state_q == S_ACCUM) ? cnt : '0;
  assign seq_if.CLR   = clr_q;
  assign seq_if.EN    = en_q;
  assign seq_if.SHIFT = shift_q;
  assign seq_if.DONE  = done_q;
  assign seq_if.BUSY  = busy_q;
  assign dbg_state_o  = state_q;

`ifdef FIR_TAP_SEQUENCER_OVR_EN
  logic ovr_q, ovr_evt;

  always_comb begin
    ovr_evt = seq_if.START &&
              ((state_q == S_CLEAR) || (state_q == S_ACCUM) || (state_q == S_SHIFT));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovr_q <= 1'b0;
    end else if (ovr_evt) begin
      ovr_q <= 1'b1;
    end
  end

  assign seq_if.OVR = ovr_q;
`else
  assign seq_if.OVR = 1'b0;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Randomized scoreboard bench for fir_tap_sequencer; model tracks the offset since the last accepted START.
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  fir_tap_sequencer_if #(.BITS_I(3)) sif ();

  fir_tap_sequencer #(
    .bits_I (3),
    .TAPS   (6)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .seq_if      (sif.slave),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [8:0]  exp_q[$];      // {BUSY, DONE, SHIFT, EN, CLR, I[2:0], OVR}, one per cycle
  logic [31:0] done_exp_q[$]; // edge index after which DONE must be seen
  int          edge_n   = 0;
  int          acc_edge = -1;
  logic        ovr_m    = 1'b0;
  int          checks   = 0;
  int          errors   = 0;

  function automatic logic [8:0] expect_vec(input int off, input logic ovr);
    logic       busy, done, shift, en, clr;
    logic [2:0] sel;
    busy  = (off >= 1) && (off <= 9);
    clr   = (off == 1);
    en    = (off >= 2) && (off <= 7);
    sel   = en ? 3'(off - 1) : 3'd0;
    shift = (off == 8);
    done  = (off == 9);
    return {busy, done, shift, en, clr, sel, ovr};
  endfunction

  // Driver: apply inputs for one edge, then advance the reference model across that edge.
  task automatic step(input logic start, input logic r);
    int cur, off;
    sif.START = start;
    rst       = r;
    @(posedge clk);
    edge_n++;
    cur = (acc_edge < 0) ? 1000 : (edge_n - acc_edge);
    if (r) begin
      acc_edge = -1;
      ovr_m    = 1'b0;
      done_exp_q.delete();
    end else if (start) begin
      if (cur >= 9) begin
        acc_edge = edge_n;
        done_exp_q.push_back(32'(edge_n + 8));
      end else begin
`ifdef FIR_TAP_SEQUENCER_OVR_EN
        ovr_m = 1'b1;
`endif
      end
    end
    off = (acc_edge < 0) ? 1000 : (edge_n - acc_edge + 1);
    exp_q.push_back(expect_vec(off, ovr_m));
    #1;
  endtask

  // Monitor: compare every presented cycle and every DONE pulse against the queues.
  always @(negedge clk) begin
    logic [8:0]  exp_v, got_v;
    logic [31:0] d;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      got_v = {sif.BUSY, sif.DONE, sif.SHIFT, sif.EN, sif.CLR, sif.I, sif.OVR};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs edge %0d: got {busy,done,shift,en,clr,i,ovr}=%b expected %b",
                 edge_n, got_v, exp_v);
      end
    end
    if (sif.DONE === 1'b1) begin
      checks++;
      if (done_exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_pulse edge %0d: got unexpected DONE expected none", edge_n);
      end else begin
        d = done_exp_q.pop_front();
        if (d != 32'(edge_n)) begin
          errors++;
          $display("FAIL done_timing: got DONE after edge %0d expected after edge %0d", edge_n, d);
        end
      end
    end
  end

  initial begin
    sif.START = 1'b0;
    rst       = 1'b1;

    // Reset held two cycles, then idle
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);

    // Single request
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Back-to-back: START in the DONE cycle
    step(1'b1, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // START during ACCUM is dropped (overrun)
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Reset mid-sequence
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0);

    // START held high
    repeat (40) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);

    // Random traffic with occasional reset
    repeat (600) step($urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
    repeat (12) step(1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (done_exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_done: got %0d outstanding DONE pulses expected 0", done_exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
